uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clock cycles per serial bit (12 MHz clock, 9600 baud); SHALL be >= 2.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two >= 2.
REQ-003 clock  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_d  input  8  byte to transmit; sampled when tx_r=1 and tx_ready=1.
REQ-006 tx_r  input  1  write strobe, level-sensitive, one byte accepted per qualifying cycle.
REQ-007 tx_ready  output  1  high when FIFO not full.
REQ-008 tx  output  1  serial line, 8N1, LSB first, idle high, registered.
REQ-009 busy  output  1  high while a frame is on the line or FIFO non-empty.
REQ-010 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky: set when tx_r=1 while tx_ready=0; cleared only by reset.

Function
REQ-012 Write accepted on a rising edge where tx_r=1 and tx_ready=1; tx_d stored at write pointer, pointer wraps modulo DEPTH.
REQ-013 tx_ready SHALL derive from registered count only (tx_ready = count<DEPTH); a write offered when full is dropped even if a pop occurs in the same cycle.
REQ-014 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-015 FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if FIFO non-empty, pop head byte into shift register, clear baud counter, go START.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-018 DATA: tx=shift[index] for CLKS_PER_BIT cycles each, index 0..7; after index 7 go STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; then if FIFO non-empty pop and go START directly (no idle gap), else go IDLE.
REQ-020 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have zero extra idle cycles.
REQ-021 Latency: byte written into empty FIFO while IDLE at edge N SHALL be popped at edge N+1, tx low from edge N+2.
REQ-022 Popped byte is held in the shift register; later FIFO writes SHALL NOT alter a frame in progress.
REQ-023 Baud counter width clog2(CLKS_PER_BIT); bit index 3 bits; no arithmetic overflow permitted.
REQ-024 busy = (state!=IDLE) or (count!=0).

Reset
REQ-025 On reset: tx=1, state=IDLE, count=0, pointers=0, tx_ready=1, busy=0, overflow=0, counters=0.
REQ-026 Reset mid-frame SHALL abort the frame, drive tx=1 on the next edge, and discard all FIFO contents.
REQ-027 Writes presented during reset SHALL be ignored.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state typedef, default CLKS_PER_BIT (1250), data width (8), and frame bit count (10).
REQ-029 FIFO storage and pointers SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty); FSM and shifter stay in uart_tx_fifo.
REQ-030 No combinational path from tx_r to tx_ready or tx.

Verification
REQ-031 Single byte 0x01, idle start -> tx: 1250 cycles low, 1250 high (bit0), 7x1250 low, 1250 high; busy low after stop.
REQ-032 Write 0x55 then 0xAA on consecutive cycles -> two frames, 20*1250 cycles total, no gap between stop of 0x55 and start of 0xAA.
REQ-033 17 consecutive writes (bytes 1..17) while line busy -> tx_ready low after 17th, count=16; 18th write dropped, overflow=1; bytes 1..17 transmitted in order.
REQ-034 Reset asserted at cycle 5000 of a frame -> tx=1 next edge, count=0, overflow=0, no further frames.
REQ-035 Loopback: bytes 1..32 with random gaps into the team's FIFObuffer receiver at 9600 baud -> all 32 received in order, unchanged.
REQ-036 CLKS_PER_BIT=2, DEPTH=4 corner build -> 20-cycle frames, pointer wrap after 4 writes with correct order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 1250;
  localparam int DATA_W           = 8;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and asynchronous read of the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a FIFO; frames are sent back to back while data is queued.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for one bit time
//   ST_DATA  | data bits, LSB first
//   ST_STOP  | stop bit (high); chains straight into the next frame if data waits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH        = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      tx_d,
  input  logic                   tx_r,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_t                r_state;
  logic [BW-1:0]         r_baud;
  logic [2:0]            r_idx;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_tx;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic [DATA_W-1:0]     w_dout;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_baud_done;

  // Acceptance depends only on the registered count, never on this cycle's pop.
  assign w_push      = tx_r & ~w_full & ~reset;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_pop       = ~w_empty &
                       ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_done));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_d),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_dout;
            r_baud  <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          r_tx <= r_shift[r_idx];
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_idx == 3'd7) r_state <= ST_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_dout;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                r_overflow <= 1'b0;
    else if (tx_r && w_full)  r_overflow <= 1'b1;
  end

  assign tx       = r_tx;
  assign tx_ready = ~w_full;
  assign count    = w_count;
  assign busy     = (r_state != ST_IDLE) | (w_count != '0);
  assign overflow = r_overflow;
endmodule
